// File: rtl/register_file_sb.sv
// Multi-ported register file with write-to-read bypass and a pending-write scoreboard.
// Issue reserves a destination, writeback fills it; decode sees per-port ready flags.
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEnable,
    input  logic [ADDR_WIDTH-1:0] wrReg,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [ADDR_WIDTH-1:0] rdReg1,
    output logic [DATA_WIDTH-1:0] rdData1,
    output logic                  rdValid1,
    input  logic [ADDR_WIDTH-1:0] rdReg2,
    output logic [DATA_WIDTH-1:0] rdData2,
    output logic                  rdValid2,
    input  logic                  issueEnable,
    input  logic [ADDR_WIDTH-1:0] issueReg,
    output logic                  issueReady,
    output logic [ADDR_WIDTH:0]   pendingCount
);

    localparam int Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [Depth];
    logic [Depth-1:0]      pending;
    logic [ADDR_WIDTH:0]   countReg;

    logic                  writeAccept;
    logic                  issueAccept;
    logic                  setBit;
    logic                  clearBit;
    logic [Depth-1:0]      pendingNext;
    logic [ADDR_WIDTH:0]   countNext;

    function automatic logic isZero(input logic [ADDR_WIDTH-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    always_comb begin
        rdData1  = regs[rdReg1];
        rdValid1 = !pending[rdReg1];
        if (isZero(rdReg1)) begin
            rdData1  = '0;
            rdValid1 = 1'b1;
        end else if (wrEnable && (wrReg == rdReg1)) begin
            rdData1  = wrData;
            rdValid1 = 1'b1;
        end
    end

    always_comb begin
        rdData2  = regs[rdReg2];
        rdValid2 = !pending[rdReg2];
        if (isZero(rdReg2)) begin
            rdData2  = '0;
            rdValid2 = 1'b1;
        end else if (wrEnable && (wrReg == rdReg2)) begin
            rdData2  = wrData;
            rdValid2 = 1'b1;
        end
    end

    // A reservation on a pending register is still accepted when its writeback lands
    // this cycle; the issue then wins, so the bit stays set and the count nets to zero.
    always_comb begin
        issueReady  = isZero(issueReg) || !pending[issueReg] ||
                      (wrEnable && (wrReg == issueReg));
        writeAccept = wrEnable && !isZero(wrReg);
        issueAccept = issueEnable && issueReady && !isZero(issueReg);
        setBit      = issueAccept && !pending[issueReg];
        clearBit    = writeAccept && pending[wrReg] &&
                      !(issueAccept && (issueReg == wrReg));
        pendingNext = pending;
        if (writeAccept) begin
            pendingNext[wrReg] = 1'b0;
        end
        if (issueAccept) begin
            pendingNext[issueReg] = 1'b1;
        end
        countNext = countReg + {{ADDR_WIDTH{1'b0}}, setBit}
                             - {{ADDR_WIDTH{1'b0}}, clearBit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs[i] <= '0;
            end
            pending  <= '0;
            countReg <= '0;
        end else begin
            if (writeAccept) begin
                regs[wrReg] <= wrData;
            end
            pending  <= pendingNext;
            countReg <= countNext;
        end
    end

    assign pendingCount = countReg;

endmodule

// File: tb/tb_register_file_sb.sv
// Table-driven scoreboard bench for register_file_sb, plus a hand-written sequence
// on a 16-bit, 8-entry instance without a zero register.
module tb_register_file_sb;

    logic        clk;
    logic        rst;
    logic        wrEnable;
    logic [4:0]  wrReg;
    logic [31:0] wrData;
    logic [4:0]  rdReg1;
    logic [31:0] rdData1;
    logic        rdValid1;
    logic [4:0]  rdReg2;
    logic [31:0] rdData2;
    logic        rdValid2;
    logic        issueEnable;
    logic [4:0]  issueReg;
    logic        issueReady;
    logic [5:0]  pendingCount;

    logic        rstB;
    logic        wrEnableB;
    logic [2:0]  wrRegB;
    logic [15:0] wrDataB;
    logic [2:0]  rdReg1B;
    logic [15:0] rdData1B;
    logic        rdValid1B;
    logic [2:0]  rdReg2B;
    logic [15:0] rdData2B;
    logic        rdValid2B;
    logic        issueEnableB;
    logic [2:0]  issueRegB;
    logic        issueReadyB;
    logic [3:0]  pendingCountB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        wrEnable;
        logic [4:0]  wrReg;
        logic [31:0] wrData;
        logic [4:0]  rdReg1;
        logic [4:0]  rdReg2;
        logic        issueEnable;
        logic [4:0]  issueReg;
        logic [31:0] expData1;
        logic        expValid1;
        logic [31:0] expData2;
        logic        expValid2;
        logic        expReady;
        logic [5:0]  expCount;
        logic        chk;
    } VecT;

    VecT vecTable[$];
    VecT expQ[$];

    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wrEnable(wrEnable), .wrReg(wrReg), .wrData(wrData),
        .rdReg1(rdReg1), .rdData1(rdData1), .rdValid1(rdValid1),
        .rdReg2(rdReg2), .rdData2(rdData2), .rdValid2(rdValid2),
        .issueEnable(issueEnable), .issueReg(issueReg), .issueReady(issueReady),
        .pendingCount(pendingCount)
    );

    register_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) dutB (
        .clk(clk), .rst(rstB), .wrEnable(wrEnableB), .wrReg(wrRegB), .wrData(wrDataB),
        .rdReg1(rdReg1B), .rdData1(rdData1B), .rdValid1(rdValid1B),
        .rdReg2(rdReg2B), .rdData2(rdData2B), .rdValid2(rdValid2B),
        .issueEnable(issueEnableB), .issueReg(issueRegB), .issueReady(issueReadyB),
        .pendingCount(pendingCountB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int r, input int w, input int wr, input logic [31:0] wd,
                       input int r1, input int r2, input int ie, input int ir,
                       input logic [31:0] d1, input int v1, input logic [31:0] d2, input int v2,
                       input int rdy, input int cnt, input int c);
        VecT v;
        v.rst = 1'(r);          v.wrEnable = 1'(w);      v.wrReg = 5'(wr);
        v.wrData = wd;          v.rdReg1 = 5'(r1);       v.rdReg2 = 5'(r2);
        v.issueEnable = 1'(ie); v.issueReg = 5'(ir);
        v.expData1 = d1;        v.expValid1 = 1'(v1);
        v.expData2 = d2;        v.expValid2 = 1'(v2);
        v.expReady = 1'(rdy);   v.expCount = 6'(cnt);    v.chk = 1'(c);
        vecTable.push_back(v);
    endtask

    // Contents of the 32-entry file once the writes of the early vectors have landed.
    function automatic logic [31:0] regVal(input int k);
        case (k)
            0:       return 32'h0;
            5:       return 32'hDEADBEEF;
            7:       return 32'd14;
            9:       return 32'h1234;
            default: return 32'(2 * k);
        endcase
    endfunction

    task automatic applyStimulus(input VecT v);
        rst         = v.rst;
        wrEnable    = v.wrEnable;
        wrReg       = v.wrReg;
        wrData      = v.wrData;
        rdReg1      = v.rdReg1;
        rdReg2      = v.rdReg2;
        issueEnable = v.issueEnable;
        issueReg    = v.issueReg;
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        VecT e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard v%0d: got empty queue, expected an entry", idx);
            return;
        end
        e = expQ.pop_front();
        if (!e.chk) return;
        checkVal($sformatf("v%0d rdData1", idx),      rdData1,           e.expData1);
        checkVal($sformatf("v%0d rdValid1", idx),     32'(rdValid1),     32'(e.expValid1));
        checkVal($sformatf("v%0d rdData2", idx),      rdData2,           e.expData2);
        checkVal($sformatf("v%0d rdValid2", idx),     32'(rdValid2),     32'(e.expValid2));
        checkVal($sformatf("v%0d issueReady", idx),   32'(issueReady),   32'(e.expReady));
        checkVal($sformatf("v%0d pendingCount", idx), 32'(pendingCount), 32'(e.expCount));
    endtask

    task automatic buildTable();
        add(1,0,0,0, 0,0, 0,0, 0,1, 0,1, 1,0, 0);
        add(0,0,0,0, 0,31, 0,5, 0,1, 0,1, 1,0, 1);
        for (int k = 0; k < 32; k++)
            add(0,1,k,32'(2*k), k,(k+1)%32, 0,k, (k==0)?32'h0:32'(2*k),1, 0,1, 1,0, 1);
        for (int k = 0; k < 32; k++)
            add(0,0,0,0, k,31-k, 0,k, (k==0)?32'h0:32'(2*k),1,
                (k==31)?32'h0:32'(2*(31-k)),1, 1,0, 1);
        // issue 5, read it stale, then write back through the bypass
        add(0,0,0,0, 5,5, 1,5, 10,1, 10,1, 1,0, 1);
        add(0,0,0,0, 5,0, 0,5, 10,0, 0,1, 0,1, 1);
        add(0,1,5,32'hDEADBEEF, 5,5, 0,5, 32'hDEADBEEF,1, 32'hDEADBEEF,1, 1,1, 1);
        add(0,0,0,0, 5,7, 0,5, 32'hDEADBEEF,1, 14,1, 1,0, 1);
        // WAW stall on reg 7
        add(0,0,0,0, 7,7, 1,7, 14,1, 14,1, 1,0, 1);
        add(0,0,0,0, 7,7, 1,7, 14,0, 14,0, 0,1, 1);
        add(0,0,0,0, 7,0, 0,7, 14,0, 0,1, 0,1, 1);
        add(0,1,7,32'd14, 7,7, 0,7, 14,1, 14,1, 1,1, 1);
        // write and re-issue the same pending register in one cycle
        add(0,0,0,0, 9,7, 1,9, 18,1, 14,1, 1,0, 1);
        add(0,1,9,32'h1234, 9,9, 1,9, 32'h1234,1, 32'h1234,1, 1,1, 1);
        add(0,0,0,0, 9,9, 0,9, 32'h1234,0, 32'h1234,0, 0,1, 1);
        add(0,1,9,32'h1234, 9,0, 0,9, 32'h1234,1, 0,1, 1,1, 1);
        for (int k = 1; k < 32; k++)
            add(0,0,0,0, k,k-1, 1,k, regVal(k),1, regVal(k-1),(k==1)?1:0, 1,k-1, 1);
        add(0,0,0,0, 0,31, 1,0, 0,1, 62,0, 1,31, 1);
        add(0,0,0,0, 3,0, 1,3, 6,0, 0,1, 0,31, 1);
        // reset wins over an in-flight write
        add(1,1,3,32'hFF, 3,4, 0,3, 32'hFF,1, 8,0, 1,31, 1);
        add(0,0,0,0, 3,4, 0,3, 0,1, 0,1, 1,0, 1);
    endtask

    initial begin
        rst = 1'b1; wrEnable = 1'b0; wrReg = '0; wrData = '0;
        rdReg1 = '0; rdReg2 = '0; issueEnable = 1'b0; issueReg = '0;
        rstB = 1'b1; wrEnableB = 1'b0; wrRegB = '0; wrDataB = '0;
        rdReg1B = '0; rdReg2B = '0; issueEnableB = 1'b0; issueRegB = '0;

        buildTable();
        for (int i = 0; i < vecTable.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecTable[i]);
            #1;
            checkOutput(i);
        end
        @(negedge clk);
        rst = 1'b0; wrEnable = 1'b0; issueEnable = 1'b0;

        @(negedge clk);
        rstB = 1'b0; wrEnableB = 1'b1; wrRegB = 3'd0; wrDataB = 16'hABCD; rdReg1B = 3'd0;
        #1;
        checkVal("B bypass rdData1", 32'(rdData1B), 32'hABCD);
        checkVal("B bypass rdValid1", 32'(rdValid1B), 32'd1);
        @(negedge clk);
        wrEnableB = 1'b0;
        #1;
        checkVal("B array rdData1", 32'(rdData1B), 32'hABCD);
        checkVal("B idle pendingCount", 32'(pendingCountB), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            issueEnableB = 1'b1; issueRegB = 3'(k);
            #1;
            checkVal($sformatf("B issue%0d issueReady", k), 32'(issueReadyB), 32'd1);
            checkVal($sformatf("B issue%0d pendingCount", k), 32'(pendingCountB), 32'(k));
        end
        @(negedge clk);
        issueEnableB = 1'b0; rdReg2B = 3'd0;
        #1;
        checkVal("B full pendingCount", 32'(pendingCountB), 32'd8);
        checkVal("B pending rdValid2", 32'(rdValid2B), 32'd0);
        checkVal("B pending rdData2", 32'(rdData2B), 32'hABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
